bcd_conv_sched: RTL and testbench
=================================

BCD_CONV_SCHED -- requirements
Module: bcd_conv_sched

Interface
REQ-001 Parameter N_REQ, 4, number of requesters sharing the converter (2..8).
REQ-002 Parameter BIN_W, 16, binary word width per requester.
REQ-003 clk_i  in  1  single clock; all state on rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-005 req_i  in  N_REQ  per-requester conversion request, level, held until granted.
REQ-006 bin_i  in  N_REQ*BIN_W  packed operands, requester k at bits [k*BIN_W +: BIN_W].
REQ-007 gnt_o  out  N_REQ  one-hot grant; high for exactly the one cycle in which the operand is captured.
REQ-008 busy_o  out  1  high in every state except IDLE.
REQ-009 valid_o  out  1  one-cycle pulse; result and ID are valid.
REQ-010 id_o  out  $clog2(N_REQ)  index of the requester whose result is on bcd_o.
REQ-011 bcd_o  out  20  digits, most significant first: {ten-thousands, thousands, hundreds, tens, units}, 4 bits each.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-013 In IDLE with any req_i high, the block SHALL assert gnt_o combinationally for the round-robin winner and capture that bin_i slice and index on the same edge.
  - Transition: IDLE to SHIFT.
REQ-014 Round-robin priority SHALL start at last_granted+1 modulo N_REQ; last_granted SHALL update only on a grant.
REQ-015 In IDLE with no req_i high, gnt_o SHALL be zero and the state SHALL remain IDLE.
REQ-016 SHIFT SHALL last exactly BIN_W cycles under a down-counter BIN_W-1..0.
  - Each cycle: add 3 to every digit >= 5, then shift {digits, operand} left by 1, operand MSB first.
REQ-017 When the counter reaches 0 in SHIFT, the next state SHALL be DONE.
REQ-018 In DONE, valid_o SHALL be 1 for one cycle with bcd_o and id_o updated; the next state SHALL be IDLE.
REQ-019 Latency: with the grant in cycle 0, valid_o SHALL be high in cycle BIN_W+1 (17).
  - Minimum spacing between successive grants is BIN_W+2 (18) cycles.
REQ-020 bcd_o and id_o SHALL hold the last result until the next DONE; they SHALL not change during SHIFT.
REQ-021 gnt_o SHALL be zero in SHIFT and DONE; requests arriving then SHALL wait, with no loss.
REQ-022 Dropping req_i before its grant SHALL have no effect.
  - A request held after its grant SHALL be treated as a new request next time it wins.
REQ-023 The largest input, 65535, SHALL convert without digit overflow; the ten-thousands digit never exceeds 6.
REQ-024 Changes on bin_i after capture SHALL not affect the conversion in progress.

Reset
REQ-025 On rst_ni low, the block SHALL enter IDLE asynchronously, including mid-SHIFT; the in-flight conversion is discarded and no valid_o follows.
REQ-026 Reset values:
  - gnt_o=0, busy_o=0, valid_o=0, id_o=0, bcd_o=0;
  - counter=0, shift register=0;
  - last_granted=N_REQ-1, so requester 0 has first priority.

Structure
REQ-027 Package bcd_pkg SHALL hold the state enumeration, DIGITS=5, DIGIT_W=4, and the default BIN_W.
REQ-028 Sub-module bcd_dabble_core SHALL own the shift register and counter.
  - Inputs: load, operand. Outputs: last-step flag, digits.
  - bcd_conv_sched SHALL hold the arbiter, FSM and output registers.

Verification
REQ-029 Requester 2 only, operand 16'hBABE -> gnt_o=4'b0100 for 1 cycle; 17 cycles later valid_o=1, id_o=2, bcd_o=4,7,8,0,6.
REQ-030 Operands 16'hFFFF and 16'h0000 -> bcd_o=6,5,5,3,5 and 0,0,0,0,0 respectively.
REQ-031 All four req_i held high from reset -> grants in order 0,1,2,3,0, spaced 18 cycles; each id_o matches its operand.
REQ-032 rst_ni pulsed low at cycle 8 of SHIFT -> busy_o=0 immediately, no valid_o, bcd_o=0; a new request converts correctly afterwards.
REQ-033 Requester 1 changes bin_i from 16'h3039 to 16'h0001 one cycle after its grant -> result 1,2,3,4,5.
REQ-034 Requester 3 raises req_i during SHIFT, requester 0 is idle -> no gnt_o until IDLE; then gnt_o=4'b1000 in the first IDLE cycle.

Source files
------------

// File: rtl/bcd_pkg.sv
// ============================================================================
// Module      : bcd_pkg
// Description : Shared types and constants for the binary-to-BCD converter
//               scheduler: FSM state encoding, digit geometry and default
//               operand width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

    // Five decimal digits cover the full 16-bit unsigned range (0..65535).
    localparam int DIGITS    = 5;
    localparam int DIGIT_W   = 4;
    localparam int BCD_W     = DIGITS * DIGIT_W;
    localparam int BIN_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : bcd_pkg

`default_nettype wire

// File: rtl/bcd_dabble_core.sv
// ============================================================================
// Module      : bcd_dabble_core
// Description : Double-dabble engine. It owns the {digits, operand} shift
//               register and the step down-counter.
//   clk_i      in   clock, rising edge
//   rst_ni     in   asynchronous active-low reset
//   load_i     in   capture operand_i and start a BIN_W-step conversion
//   operand_i  in   binary operand
//   last_o     out  high during the final step of a conversion
//   digits_o   out  digits produced by the current step, most significant
//                   first (complete result while last_o is high)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_dabble_core
    import bcd_pkg::*;
#(
    parameter int BIN_W = BIN_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [BIN_W-1:0] operand_i,
    output logic             last_o,
    output logic [BCD_W-1:0] digits_o
);

    localparam int c_CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam int c_SR_W  = BCD_W + BIN_W;

    logic [c_SR_W-1:0]  r_sr;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_active;
    logic [BCD_W-1:0]   w_adj;
    logic [c_SR_W-1:0]  w_step;

    // Add-3 correction: any digit >= 5 would become >= 10 after the shift.
    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        logic [DIGIT_W-1:0] w_dig;
        assign w_dig = r_sr[BIN_W + d*DIGIT_W +: DIGIT_W];
        assign w_adj[d*DIGIT_W +: DIGIT_W] =
            (w_dig >= DIGIT_W'(5)) ? (w_dig + DIGIT_W'(3)) : w_dig;
    end

    assign w_step   = {w_adj, r_sr[BIN_W-1:0]} << 1;
    assign digits_o = w_step[c_SR_W-1:BIN_W];
    assign last_o   = r_active && (r_cnt == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sr     <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (load_i) begin
            r_sr     <= {{BCD_W{1'b0}}, operand_i};
            r_cnt    <= c_CNT_W'(BIN_W - 1);
            r_active <= 1'b1;
        end else if (r_active) begin
            r_sr <= w_step;
            if (r_cnt == '0) begin
                r_active <= 1'b0;
            end else begin
                r_cnt <= r_cnt - c_CNT_W'(1);
            end
        end
    end

endmodule : bcd_dabble_core

`default_nettype wire

// File: rtl/bcd_conv_sched.sv
// ============================================================================
// Module      : bcd_conv_sched
// Description : Round-robin scheduler sharing one binary-to-BCD converter
//               among N_REQ requesters.
//   clk_i    in   clock, rising edge
//   rst_ni   in   asynchronous active-low reset
//   req_i    in   per-requester level request, held until granted
//   bin_i    in   packed operands, requester k at [k*BIN_W +: BIN_W]
//   gnt_o    out  one-hot grant, high in the operand-capture cycle only
//   busy_o   out  high whenever the FSM is not idle
//   valid_o  out  one-cycle result strobe
//   id_o     out  requester index of the result on bcd_o
//   bcd_o    out  {ten-thousands, thousands, hundreds, tens, units}
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_conv_sched
    import bcd_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int BIN_W = BIN_W_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [N_REQ-1:0]         req_i,
    input  logic [N_REQ*BIN_W-1:0]   bin_i,
    output logic [N_REQ-1:0]         gnt_o,
    output logic                     busy_o,
    output logic                     valid_o,
    output logic [$clog2(N_REQ)-1:0] id_o,
    output logic [BCD_W-1:0]         bcd_o
);

    localparam int c_ID_W = $clog2(N_REQ);

    state_t              r_state;
    logic [c_ID_W-1:0]   r_last;
    logic [c_ID_W-1:0]   r_id_cur;
    logic [c_ID_W-1:0]   r_id;
    logic [BCD_W-1:0]    r_bcd;
    logic                r_valid;

    logic                w_found;
    logic [c_ID_W-1:0]   w_win;
    logic                w_load;
    logic                w_last;
    logic [BCD_W-1:0]    w_digits;

    // Round-robin search starting one past the most recent grant.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            int idx;
            idx = (int'(r_last) + 1 + i) % N_REQ;
            if (!w_found && req_i[idx]) begin
                w_found = 1'b1;
                w_win   = c_ID_W'(idx);
            end
        end
    end

    assign w_load  = (r_state == ST_IDLE) && w_found;
    assign gnt_o   = w_load ? (N_REQ'(1) << w_win) : '0;
    assign busy_o  = (r_state != ST_IDLE);
    assign valid_o = r_valid;
    assign id_o    = r_id;
    assign bcd_o   = r_bcd;

    bcd_dabble_core #(
        .BIN_W (BIN_W)
    ) u_core (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .load_i    (w_load),
        .operand_i (bin_i[w_win*BIN_W +: BIN_W]),
        .last_o    (w_last),
        .digits_o  (w_digits)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= ST_IDLE;
            r_last   <= c_ID_W'(N_REQ - 1);
            r_id_cur <= '0;
            r_id     <= '0;
            r_bcd    <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_last   <= w_win;
                        r_id_cur <= w_win;
                        r_state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // The core's final step result is taken directly so the
                    // strobe lands in the cycle after the last shift.
                    if (w_last) begin
                        r_bcd   <= w_digits;
                        r_id    <= r_id_cur;
                        r_valid <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule : bcd_conv_sched

`default_nettype wire

// File: tb/tb_bcd_conv_sched.sv
// ============================================================================
// Module      : tb_bcd_conv_sched
// Description : Scoreboard bench for bcd_conv_sched (N_REQ=4, BIN_W=16).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_conv_sched;

    localparam int N_REQ = 4;
    localparam int BIN_W = 16;

    logic                   clk_i = 1'b0;
    logic                   rst_ni;
    logic [N_REQ-1:0]       req_i;
    logic [N_REQ*BIN_W-1:0] bin_i;
    logic [N_REQ-1:0]       gnt_o;
    logic                   busy_o;
    logic                   valid_o;
    logic [1:0]             id_o;
    logic [19:0]            bcd_o;

    typedef struct {
        logic [1:0]  id;
        logic [19:0] bcd;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int unsigned cyc   = 0;
    logic [19:0] last_bcd = '0;

    bcd_conv_sched #(.N_REQ(N_REQ), .BIN_W(BIN_W)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req_i   (req_i),
        .bin_i   (bin_i),
        .gnt_o   (gnt_o),
        .busy_o  (busy_o),
        .valid_o (valid_o),
        .id_o    (id_o),
        .bcd_o   (bcd_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] to_bcd(input int unsigned v);
        return {4'(v / 10000), 4'((v / 1000) % 10), 4'((v / 100) % 10),
                4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Monitor: grants push expectations, valid strobes pop and compare.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            sb.delete();
            last_bcd = '0;
        end else begin
            if (gnt_o != '0) begin
                exp_t e;
                int   k;
                k = 0;
                for (int i = 0; i < N_REQ; i++) if (gnt_o[i]) k = i;
                chk("gnt_onehot", 32'($onehot(gnt_o)), 32'd1);
                e.id  = 2'(k);
                e.bcd = to_bcd(int'(bin_i[k*BIN_W +: BIN_W]));
                e.cyc = cyc;
                sb.push_back(e);
            end
            if (valid_o) begin
                if (sb.size() == 0) begin
                    chk("spurious_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("id", 32'(id_o), 32'(e.id));
                    chk("bcd", 32'(bcd_o), 32'(e.bcd));
                    chk("latency", cyc - e.cyc, 32'd17);
                    last_bcd = e.bcd;
                end
            end else if (busy_o) begin
                chk("bcd_hold", 32'(bcd_o), 32'(last_bcd));
            end
        end
    end

    task automatic wait_gnt(input int k);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk_i);
            if (gnt_o[k]) ok = 1'b1;
        end
        if (!ok) chk("gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk_i);
            if (!busy_o) ok = 1'b1;
        end
        if (!ok) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_conv(input int k, input logic [15:0] v, input bit chg, input logic [15:0] v2);
        @(posedge clk_i); #1;
        bin_i[k*BIN_W +: BIN_W] = v;
        req_i[k] = 1'b1;
        wait_gnt(k);
        chk("gnt_vec", 32'(gnt_o), 32'(1 << k));
        @(posedge clk_i); #1;
        req_i[k] = 1'b0;
        if (chg) bin_i[k*BIN_W +: BIN_W] = v2;
        wait_idle();
    endtask

    initial begin
        int unsigned t_prev;
        rst_ni = 1'b0;
        req_i  = '0;
        bin_i  = '0;
        repeat (3) @(negedge clk_i);
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_id", 32'(id_o), 32'd0);
        chk("rst_bcd", 32'(bcd_o), 32'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

        // Single requester, then range extremes and a post-capture change.
        do_conv(2, 16'hBABE, 1'b0, 16'h0);
        do_conv(0, 16'hFFFF, 1'b0, 16'h0);
        do_conv(3, 16'h0000, 1'b0, 16'h0);
        do_conv(1, 16'h3039, 1'b1, 16'h0001);
        for (int i = 0; i < 40; i++) begin
            automatic logic [15:0] r = 16'($urandom);
            do_conv(int'($urandom_range(0, 3)), r, 1'b0, 16'h0);
        end

        // All requesters held from reset: strict round-robin, 18-cycle spacing.
        rst_ni = 1'b0;
        bin_i  = {16'd4444, 16'd33333, 16'd222, 16'd11};
        req_i  = 4'hF;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        t_prev = 0;
        for (int n = 0; n < 5; n++) begin
            wait_gnt(n % 4);
            chk("rr_gnt", 32'(gnt_o), 32'(1 << (n % 4)));
            if (n > 0) chk("rr_spacing", cyc - t_prev, 32'd18);
            t_prev = cyc;
        end
        @(posedge clk_i); #1;
        req_i = '0;
        wait_idle();

        // Request arriving during SHIFT waits for IDLE.
        do_conv(1, 16'd500, 1'b0, 16'h0);
        @(posedge clk_i); #1;
        req_i[1] = 1'b1;
        bin_i[1*BIN_W +: BIN_W] = 16'd777;
        wait_gnt(1);
        @(posedge clk_i); #1;
        req_i[1] = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        req_i[3] = 1'b1;
        bin_i[3*BIN_W +: BIN_W] = 16'd9876;
        for (int i = 0; i < 40 && busy_o; i++) begin
            @(negedge clk_i);
            if (busy_o) chk("gnt_while_busy", 32'(gnt_o), 32'd0);
        end
        chk("gnt_first_idle", 32'(gnt_o), 32'b1000);
        @(posedge clk_i); #1;
        req_i[3] = 1'b0;
        wait_idle();

        // Asynchronous reset in SHIFT cycle 8 discards the conversion.
        @(posedge clk_i); #1;
        bin_i[0 +: BIN_W] = 16'd1234;
        req_i[0] = 1'b1;
        wait_gnt(0);
        @(posedge clk_i); #1;
        req_i[0] = 1'b0;
        repeat (7) @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_bcd", 32'(bcd_o), 32'd0);
        chk("arst_valid", 32'(valid_o), 32'd0);
        #4;
        rst_ni = 1'b1;
        repeat (25) @(negedge clk_i);
        do_conv(2, 16'd54321, 1'b0, 16'h0);

        repeat (3) @(negedge clk_i);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_bcd_conv_sched

`default_nettype wire
